hazard_ctrl_sb: RTL and testbench

//  Scoreboarded hazard controller for the 5-stage core; successor to the fixed load-use/div hazard logic.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/reg_scoreboard.sv | 67 ++++++
 rtl/hazard_ctrl_sb.sv | 105 ++++++++++
 tb/tb_hazard_ctrl_sb.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the scoreboarded hazard controller: forwarding selects,
// stall-reason tags for debug tracing and the pipeline NOP encoding.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [2:0] {
        NONE,
        LOAD_USE,
        SB_RAW,
        SB_WAW,
        SB_FULL,
        CACHE
    } stall_reason_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy table for outstanding long-latency writes, with an
// outstanding-op count that caps how many such ops may be in flight.
module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int MAX_LONG = 4,
    parameter int RA_W     = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_req,
    input  logic                issue_hold,
    input  logic                issue_wr,
    input  logic [RA_W-1:0]     issue_rd,
    input  logic                done,
    input  logic [RA_W-1:0]     done_rd,
    input  logic [RA_W-1:0]     rd_a,
    input  logic [RA_W-1:0]     rd_b,
    output logic                busy_a,
    output logic                busy_b,
    output logic                full,
    output logic [NUM_REGS-1:0] busy
);

    localparam int CW = $clog2(MAX_LONG + 1);

    logic [CW-1:0]       count;
    logic [NUM_REGS-1:0] busy_nxt;
    logic                accept;
    logic                set_en;
    logic                dec;

    // A retiring op frees a slot in the same cycle, so the E op is not held.
    assign full   = (count == CW'(MAX_LONG)) & issue_req & ~done;
    assign accept = issue_req & ~issue_hold & ~full;
    assign set_en = accept & issue_wr & (issue_rd != '0);
    assign dec    = done & (count != '0);

    assign busy_a = busy[rd_a];
    assign busy_b = busy[rd_b];

    // Clear first so a same-cycle set of the same register wins.
    always_comb begin
        busy_nxt = busy;
        if (done)
            busy_nxt[done_rd] = 1'b0;
        if (set_en)
            busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= '0;
            count <= '0;
        end else begin
            busy <= busy_nxt;
            case ({accept, dec})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) done |-> (count != '0));

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Hazard controller for the 5-stage core: forwarding selects, load-use and
// scoreboard stalls, cache-miss freeze, branch flush and stall counters.
module hazard_ctrl_sb
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int RA_W     = $clog2(NUM_REGS),
    parameter int MAX_LONG = 4,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [RA_W-1:0]     rs1_d,
    input  logic [RA_W-1:0]     rs2_d,
    input  logic                rs1_used_d,
    input  logic                rs2_used_d,
    input  logic [RA_W-1:0]     rd_d,
    input  logic                reg_write_d,
    input  logic [RA_W-1:0]     rs1_e,
    input  logic [RA_W-1:0]     rs2_e,
    input  logic                rs1_used_e,
    input  logic                rs2_used_e,
    input  logic [RA_W-1:0]     rd_e,
    input  logic                reg_write_e,
    input  logic                load_e,
    input  logic                long_issue_e,
    input  logic                long_done,
    input  logic [RA_W-1:0]     long_done_rd,
    input  logic [RA_W-1:0]     rd_m,
    input  logic                reg_write_m,
    input  logic [RA_W-1:0]     rd_w,
    input  logic                reg_write_w,
    input  logic                branch_taken,
    input  logic                mem_ready_m,
    output fwd_sel_e            fwd_rs1,
    output fwd_sel_e            fwd_rs2,
    output logic                stall_d,
    output logic                bubble_e,
    output logic                freeze,
    output logic                flush,
    output logic [NUM_REGS-1:0] sb_busy,
    output logic [CNT_W-1:0]    stall_cycles,
    output logic [CNT_W-1:0]    flush_count
);

    logic busy_rs1, busy_rs2, full;
    logic raw_ld, raw_sb, waw_sb;

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .MAX_LONG (MAX_LONG),
        .RA_W     (RA_W)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_req  (long_issue_e),
        .issue_hold (freeze),
        .issue_wr   (reg_write_e),
        .issue_rd   (rd_e),
        .done       (long_done),
        .done_rd    (long_done_rd),
        .rd_a       (rs1_d),
        .rd_b       (rs2_d),
        .busy_a     (busy_rs1),
        .busy_b     (busy_rs2),
        .full       (full),
        .busy       (sb_busy)
    );

    // M is younger than W, so its value is the one the E op must see.
    function automatic fwd_sel_e fwd_pick(input logic used, input logic [RA_W-1:0] rs);
        if (used && reg_write_m && (rd_m != '0) && (rd_m == rs))
            return FWD_MEM;
        if (used && reg_write_w && (rd_w != '0) && (rd_w == rs))
            return FWD_WB;
        return FWD_RF;
    endfunction

    assign fwd_rs1 = fwd_pick(rs1_used_e, rs1_e);
    assign fwd_rs2 = fwd_pick(rs2_used_e, rs2_e);

    assign raw_ld = load_e & reg_write_e & (rd_e != '0) &
                    ((rs1_used_d & (rd_e == rs1_d)) | (rs2_used_d & (rd_e == rs2_d)));
    assign raw_sb = (rs1_used_d & busy_rs1) | (rs2_used_d & busy_rs2);
    assign waw_sb = reg_write_d & sb_busy[rd_d];

    assign freeze   = ~mem_ready_m;
    assign flush    = branch_taken & ~freeze;
    assign stall_d  = (raw_ld | raw_sb | waw_sb | full) & ~flush & ~freeze;
    // When the scoreboard is full the E op itself waits, so no bubble.
    assign bubble_e = stall_d & ~full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if ((stall_d | freeze) && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (flush && (flush_count != '1))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Directed and randomized checks of hazard_ctrl_sb against a queue-based
// model of outstanding long-latency ops and the hazard rules.
module tb_hazard_ctrl_sb;
    import hazard_pkg::*;

    localparam int NR = 32;
    localparam int RW = 5;
    localparam int ML = 4;
    localparam int CW = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [RW-1:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, long_done_rd, rd_m, rd_w;
    logic rs1_used_d, rs2_used_d, reg_write_d, rs1_used_e, rs2_used_e, reg_write_e;
    logic load_e, long_issue_e, long_done, reg_write_m, reg_write_w, branch_taken, mem_ready_m;
    fwd_sel_e fwd_rs1, fwd_rs2;
    logic stall_d, bubble_e, freeze, flush;
    logic [NR-1:0] sb_busy;
    logic [CW-1:0] stall_cycles, flush_count;

    int checks = 0;
    int errors = 0;

    // Model state
    bit m_busy[NR];
    int pend[$];
    int m_stall, m_flush;
    bit e_freeze, e_flush, e_full, e_stall, e_bubble;

    always #5 clk = ~clk;

    hazard_ctrl_sb #(.NUM_REGS(NR), .MAX_LONG(ML), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d),
        .rd_d(rd_d), .reg_write_d(reg_write_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rs1_used_e(rs1_used_e), .rs2_used_e(rs2_used_e),
        .rd_e(rd_e), .reg_write_e(reg_write_e), .load_e(load_e),
        .long_issue_e(long_issue_e), .long_done(long_done), .long_done_rd(long_done_rd),
        .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
        .branch_taken(branch_taken), .mem_ready_m(mem_ready_m),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .stall_d(stall_d), .bubble_e(bubble_e),
        .freeze(freeze), .flush(flush), .sb_busy(sb_busy),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        {rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, long_done_rd, rd_m, rd_w} = '0;
        {rs1_used_d, rs2_used_d, reg_write_d, rs1_used_e, rs2_used_e, reg_write_e} = '0;
        {load_e, long_issue_e, long_done, reg_write_m, reg_write_w, branch_taken} = '0;
        mem_ready_m = 1'b1;
    endtask

    task automatic model_reset();
        foreach (m_busy[k]) m_busy[k] = 1'b0;
        pend.delete();
        m_stall = 0;
        m_flush = 0;
    endtask

    function automatic logic [1:0] e_fwd(input bit used, input logic [RW-1:0] rs);
        if (used && reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (used && reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [NR-1:0] m_busy_vec();
        logic [NR-1:0] v;
        for (int k = 0; k < NR; k++) v[k] = m_busy[k];
        return v;
    endfunction

    task automatic check_comb(input string tag);
        bit raw_ld, raw_sb, waw;
        e_freeze = !mem_ready_m;
        e_flush  = branch_taken && !e_freeze;
        e_full   = (pend.size() == ML) && long_issue_e && !long_done;
        raw_ld = load_e && reg_write_e && rd_e != 0 &&
                 ((rs1_used_d && rd_e == rs1_d) || (rs2_used_d && rd_e == rs2_d));
        raw_sb = (rs1_used_d && m_busy[rs1_d]) || (rs2_used_d && m_busy[rs2_d]);
        waw    = reg_write_d && m_busy[rd_d];
        e_stall  = (raw_ld || raw_sb || waw || e_full) && !e_flush && !e_freeze;
        e_bubble = e_stall && !e_full;
        chk({tag, ".fwd_rs1"}, fwd_rs1, e_fwd(rs1_used_e, rs1_e));
        chk({tag, ".fwd_rs2"}, fwd_rs2, e_fwd(rs2_used_e, rs2_e));
        chk({tag, ".stall_d"}, stall_d, e_stall);
        chk({tag, ".bubble_e"}, bubble_e, e_bubble);
        chk({tag, ".freeze"}, freeze, e_freeze);
        chk({tag, ".flush"}, flush, e_flush);
    endtask

    // Accepted ops join the outstanding list; a writeback retires the op that named that register.
    task automatic model_update();
        bit accept;
        accept = long_issue_e && !e_freeze && !e_full;
        if (long_done) begin
            m_busy[long_done_rd] = 1'b0;
            for (int k = 0; k < pend.size(); k++)
                if (pend[k] == long_done_rd) begin pend.delete(k); break; end
        end
        if (accept) begin
            pend.push_back(rd_e);
            if (reg_write_e && rd_e != 0) m_busy[rd_e] = 1'b1;
        end
        if ((e_stall || e_freeze) && m_stall < CMAX) m_stall++;
        if (e_flush && m_flush < CMAX) m_flush++;
    endtask

    task automatic tick(input string tag);
        #1 check_comb(tag);
        @(posedge clk);
        model_update();
        #1;
        chk({tag, ".sb_busy"}, sb_busy, m_busy_vec());
        chk({tag, ".stall_cycles"}, stall_cycles, m_stall);
        chk({tag, ".flush_count"}, flush_count, m_flush);
    endtask

    task automatic issue(input int rd);
        idle();
        long_issue_e = 1'b1; reg_write_e = 1'b1; rd_e = RW'(rd);
        tick("issue");
    endtask

    task automatic drain();
        for (int n = 0; n < 64 && pend.size() > 0; n++) begin
            idle();
            long_done = 1'b1; long_done_rd = RW'(pend[0]);
            tick("drain");
        end
        chk("drain_empty", pend.size(), 0);
        idle();
    endtask

    initial begin
        model_reset();
        idle();
        rst_n = 1'b0;
        #3;
        chk("rst.sb_busy", sb_busy, 0);
        chk("rst.stall_cycles", stall_cycles, 0);
        chk("rst.flush_count", flush_count, 0);
        chk("rst.stall_d", stall_d, 0);
        chk("rst.fwd_rs1", fwd_rs1, 2'b00);
        mem_ready_m = 1'b0;
        #1 chk("rst.freeze", freeze, 1);
        mem_ready_m = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;

        // Forwarding priority
        rs1_e = 5; rs1_used_e = 1; rd_m = 5; rd_w = 5; reg_write_m = 1; reg_write_w = 1;
        rs2_e = 5; rs2_used_e = 1;
        #1 chk("fwd.mem", fwd_rs1, 2'b10);
        tick("fwd_mem");
        reg_write_m = 0;
        #1 chk("fwd.wb", fwd_rs1, 2'b01);
        tick("fwd_wb");
        reg_write_m = 1; rd_m = 0; rd_w = 0;
        #1 chk("fwd.x0", fwd_rs1, 2'b00);
        tick("fwd_x0");

        // Load-use
        idle();
        load_e = 1; reg_write_e = 1; rd_e = 7; rs2_d = 7; rs2_used_d = 1;
        #1 chk("ld.stall", stall_d, 1);
        chk("ld.bubble", bubble_e, 1);
        tick("ld_use");
        rs2_used_d = 0;
        #1 chk("ld.unused", stall_d, 0);
        tick("ld_unused");

        // Divide RAW: stall until writeback, clear the cycle after
        issue(9);
        idle(); rs1_d = 9; rs1_used_d = 1;
        for (int n = 0; n < 3; n++) begin
            #1 chk("div.stall", stall_d, 1);
            tick("div_wait");
        end
        long_done = 1; long_done_rd = 9;
        tick("div_done");
        long_done = 0;
        #1 chk("div.released", stall_d, 0);
        tick("div_after");

        // Full scoreboard, then WAW
        for (int r = 1; r <= 4; r++) issue(r);
        idle(); long_issue_e = 1; reg_write_e = 1; rd_e = 5;
        #1 chk("full.stall", stall_d, 1);
        chk("full.bubble", bubble_e, 0);
        tick("full");
        chk("full.busy", sb_busy, 32'h1E);
        idle(); reg_write_d = 1; rd_d = 2;
        #1 chk("waw.stall", stall_d, 1);
        tick("waw1");
        tick("waw2");
        long_done = 1; long_done_rd = 2;
        tick("waw_done");
        long_done = 0;
        #1 chk("waw.released", stall_d, 0);
        tick("waw_after");
        drain();

        // Same-cycle set and clear of x3
        issue(3);
        idle(); long_done = 1; long_done_rd = 3; long_issue_e = 1; reg_write_e = 1; rd_e = 3;
        tick("setclr");
        chk("setclr.busy3", sb_busy[3], 1);
        issue(1); issue(2); issue(4);
        idle(); long_issue_e = 1; reg_write_e = 1; rd_e = 6;
        #1 chk("setclr.count_full", stall_d, 1);
        tick("setclr_full");
        drain();

        // Flush beats load-use; freeze blocks issue
        load_e = 1; reg_write_e = 1; rd_e = 7; rs1_d = 7; rs1_used_d = 1; branch_taken = 1;
        #1 chk("flush.flush", flush, 1);
        chk("flush.stall", stall_d, 0);
        tick("flush");
        idle(); mem_ready_m = 0; long_issue_e = 1; reg_write_e = 1; rd_e = 10;
        #1 chk("frz.freeze", freeze, 1);
        chk("frz.stall", stall_d, 0);
        tick("freeze");
        chk("frz.no_set", sb_busy[10], 0);
        idle();

        // Asynchronous reset mid-divide
        issue(11);
        idle();
        #2 rst_n = 1'b0;
        #1 chk("arst.sb_busy", sb_busy, 0);
        chk("arst.stall_cycles", stall_cycles, 0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            idle();
            rs1_d = RW'($urandom_range(0, 7)); rs2_d = RW'($urandom_range(0, 7));
            rd_d  = RW'($urandom_range(0, 7));
            rs1_e = RW'($urandom_range(0, 7)); rs2_e = RW'($urandom_range(0, 7));
            rd_e  = RW'($urandom_range(0, 7));
            rd_m  = RW'($urandom_range(0, 7)); rd_w  = RW'($urandom_range(0, 7));
            {rs1_used_d, rs2_used_d, reg_write_d} = 3'($urandom);
            {rs1_used_e, rs2_used_e, reg_write_e} = 3'($urandom);
            {reg_write_m, reg_write_w} = 2'($urandom);
            load_e       = ($urandom_range(0, 3) == 0);
            long_issue_e = ($urandom_range(0, 2) == 0);
            branch_taken = ($urandom_range(0, 9) == 0);
            mem_ready_m  = ($urandom_range(0, 9) != 0);
            if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
                long_done = 1; long_done_rd = RW'(pend[0]);
            end
            tick("rnd");
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
